rom_download_router: RTL and testbench
======================================

Name: rom_download_router

Overview:
- Generalised ROM-download front end between data_io's ioctl stream and the sdram toggle-handshake ports.
- Routes each downloaded byte to exactly one of NUM_PORTS SDRAM ports by address region, rather than toggling all ports on every write.
- Waits for each port's ack, absorbs back-to-back writes in a one-deep buffer, and owns the rom_loaded flag and stretched core reset.
- Sits in the core top between data_io and sdram; clk_sys is the SDRAM clock domain.

Parameters:
- NUM_PORTS, 2: number of SDRAM request ports (1..4).
- ADDR_W, 25: ioctl_addr width.
- PORT_AW, 23: word-address width per port.
- REGION_BASE, {25'h10000, 25'h00000}: packed NUM_PORTS×ADDR_W byte base addresses, ascending. Port k owns [BASE[k], BASE[k+1]); the last port owns [BASE[last], top].
- DL_INDEX, 8'h00: ioctl_index value accepted.
- INDEX_MASK, 8'h00: bits of ioctl_index compared against DL_INDEX; 0 accepts every index.
- RESET_STRETCH, 16: cycles core_reset stays high after its release condition.

Ports:
- clk_sys  in  1  clock
- reset  in  1  asynchronous, active-high
- user_reset  in  1  OSD reset, status[0]
- ioctl_downl  in  1  download active
- ioctl_index  in  8  download index
- ioctl_wr  in  1  byte strobe, level; rising edge used
- ioctl_addr  in  ADDR_W  byte address
- ioctl_dout  in  8  byte data
- port_req  out  NUM_PORTS  toggle request per port
- port_ack  in  NUM_PORTS  toggle ack per port
- port_a  out  PORT_AW  shared word address, (ioctl_addr−BASE[k])>>1
- port_ds  out  2  {addr[0], ~addr[0]}
- port_d  out  16  {dout, dout}
- port_we  out  1  mirrors ioctl_downl
- rom_loaded  out  1  download completed
- core_reset  out  1  reset to game core
- overflow  out  1  sticky: a byte was dropped
- bytes_written  out  ADDR_W  count of bytes acked in the current download

Behaviour:
- Reset values: port_req=0, port_a=0, port_ds=0, port_d=0, rom_loaded=0, core_reset=1, overflow=0, bytes_written=0, stretch counter=RESET_STRETCH, pending empty, state IDLE.
- Reset is asynchronous; mid-transfer reset returns to IDLE and drops pending.
- Accept: registered edge detect. A byte is accepted when ioctl_wr is high and was low last cycle, ioctl_downl=1, and ((ioctl_index^DL_INDEX)&INDEX_MASK)==0. Address and data are captured in the same cycle.
- Region select: highest k with ioctl_addr ≥ BASE[k]. Addresses below BASE[0] are ignored; they are not counted and do not set overflow.
- FSM IDLE:
  - On accept, or with pending valid, load port_a/ds/d.
  - Toggle port_req[k] one cycle after capture.
  - Go to WAIT_ACK. Pending has priority over a same-cycle new accept; the new byte goes into pending.
- FSM WAIT_ACK:
  - Exit when port_ack[k]==port_req[k]; then bytes_written+1 and return to IDLE.
  - Earliest next issue is the following cycle.
- Buffering:
  - An accept in WAIT_ACK fills the one-deep pending register.
  - An accept while pending is full sets overflow and drops the byte.
- Download start: the rising edge of ioctl_downl clears rom_loaded, bytes_written and overflow.
- Completion:
  - On the falling edge of ioctl_downl, set a done_req flag.
  - rom_loaded goes to 1 when done_req=1, FSM in IDLE, pending empty and bytes_written≠0.
  - A zero-byte download leaves rom_loaded=0.
- core_reset:
  - Forced to 1 and the counter reloaded while user_reset=1 or rom_loaded=0.
  - Otherwise the counter decrements each cycle; core_reset=0 when the counter reaches 0.
  - Release occurs exactly RESET_STRETCH cycles after the condition clears.
- port_we is combinational from ioctl_downl; all other outputs are registered.

Decomposition:
- Shared package rom_dl_pkg:
  - state enum (IDLE, WAIT_ACK)
  - function region_of(addr, bases)
  - localparam DS_LO=2'b01, DS_HI=2'b10
- One sub-module, toggle_req_port: per-port req flip-flop plus ack-compare busy output, instantiated NUM_PORTS times.

Test Plan:
- Defaults, ack echoed after 3 cycles. Write addr 0x00004=0xA5 → port_req[0] toggles, port_a=0x2, ds=2'b01, d=16'hA5A5; port_req[1] unchanged; bytes_written=1.
- Write addr 0x10003=0x5A → only port_req[1] toggles; port_a=0x1, ds=2'b10.
- Hold ack 10 cycles, send 3 rising edges of ioctl_wr → bytes 1 and 2 issue in order, byte 3 dropped, overflow=1, bytes_written=2.
- Download of 4 bytes, then drop ioctl_downl while the last ack is outstanding → rom_loaded rises only after the ack; core_reset falls exactly 16 cycles later.
- INDEX_MASK=8'hFF, DL_INDEX=1, stream with index 0 → no req toggles, rom_loaded stays 0, core_reset stays 1.
- Assert reset mid-WAIT_ACK → all outputs return to reset values within the same cycle; user_reset pulse after loading → core_reset high for pulse+16 cycles.

Source files
------------

// File: rtl/rom_dl_pkg.sv
// Shared types and helpers for the ROM download router: FSM states, byte-lane
// strobes and the address-to-region lookup.
package rom_dl_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  localparam logic [1:0] DS_LO = 2'b01;
  localparam logic [1:0] DS_HI = 2'b10;

  localparam int MAX_PORTS = 4;
  localparam int MAX_AW    = 32;

  // Highest region whose base is <= addr; -1 when addr sits below every base.
  function automatic int region_of(input logic [MAX_AW-1:0] addr,
                                   input logic [MAX_PORTS-1:0][MAX_AW-1:0] bases,
                                   input int n);
    int r;
    r = -1;
    for (int k = 0; k < MAX_PORTS; k++)
      if (k < n && addr >= bases[k]) r = k;
    return r;
  endfunction

endpackage

// File: rtl/rom_download_router_port.sv
// One SDRAM toggle-handshake request port: req flips on i_toggle, busy while
// the ack has not yet caught up with req.
module toggle_req_port (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_toggle,
  input  logic i_ack,
  output logic o_req,
  output logic o_busy
);

  logic r_req;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)         r_req <= 1'b0;
    else if (i_toggle) r_req <= ~r_req;
  end

  assign o_req  = r_req;
  assign o_busy = r_req ^ i_ack;

endmodule

// File: rtl/rom_download_router.sv
// ROM download front end: routes each ioctl byte to the SDRAM port owning its
// address region, buffers one byte while busy, and owns rom_loaded/core_reset.
module rom_download_router
  import rom_dl_pkg::*;
#(
  parameter int                          NUM_PORTS     = 2,
  parameter int                          ADDR_W        = 25,
  parameter int                          PORT_AW       = 23,
  parameter logic [NUM_PORTS*ADDR_W-1:0] REGION_BASE   = {25'h10000, 25'h00000},
  parameter logic [7:0]                  DL_INDEX      = 8'h00,
  parameter logic [7:0]                  INDEX_MASK    = 8'h00,
  parameter int                          RESET_STRETCH = 16
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 user_reset,
  input  logic                 ioctl_downl,
  input  logic [7:0]           ioctl_index,
  input  logic                 ioctl_wr,
  input  logic [ADDR_W-1:0]    ioctl_addr,
  input  logic [7:0]           ioctl_dout,
  output logic [NUM_PORTS-1:0] port_req,
  input  logic [NUM_PORTS-1:0] port_ack,
  output logic [PORT_AW-1:0]   port_a,
  output logic [1:0]           port_ds,
  output logic [15:0]          port_d,
  output logic                 port_we,
  output logic                 rom_loaded,
  output logic                 core_reset,
  output logic                 overflow,
  output logic [ADDR_W-1:0]    bytes_written
);

  localparam int CW = (RESET_STRETCH < 2) ? 1 : $clog2(RESET_STRETCH + 1);

  state_t                 r_state, w_state_nxt;
  logic                   r_issue;
  logic [NUM_PORTS-1:0]   r_cur_oh;
  logic [PORT_AW-1:0]     r_a;
  logic [1:0]             r_ds;
  logic [15:0]            r_d;
  logic                   r_pend_vld;
  logic [NUM_PORTS-1:0]   r_pend_oh;
  logic [PORT_AW-1:0]     r_pend_a;
  logic [1:0]             r_pend_ds;
  logic [15:0]            r_pend_d;
  logic                   r_wr_d, r_downl_d;
  logic [ADDR_W-1:0]      r_bytes;
  logic                   r_ovf, r_loaded, r_done_req;
  logic [CW-1:0]          r_cnt;
  logic                   r_core_rst;

  logic [MAX_PORTS-1:0][MAX_AW-1:0] w_bases;
  logic [MAX_AW-1:0]      w_addr, w_base_sel, w_off;
  int                     w_region;
  logic [NUM_PORTS-1:0]   w_new_oh, w_busy, w_req;
  logic [PORT_AW-1:0]     w_new_a;
  logic [1:0]             w_new_ds;
  logic [15:0]            w_new_d;
  logic                   w_idx_ok, w_accept, w_downl_rise, w_downl_fall;
  logic                   w_issue_new, w_issue_pend, w_fill_pend, w_drop, w_done;

  always_comb begin
    w_bases = '0;
    for (int k = 0; k < NUM_PORTS; k++)
      w_bases[k] = MAX_AW'(REGION_BASE[k*ADDR_W +: ADDR_W]);
  end

  assign w_addr   = MAX_AW'(ioctl_addr);
  assign w_region = region_of(w_addr, w_bases, NUM_PORTS);

  always_comb begin
    w_new_oh   = '0;
    w_base_sel = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_new_oh[k] = (w_region == k);
      if (w_region == k) w_base_sel = w_bases[k];
    end
  end

  assign w_off    = w_addr - w_base_sel;
  assign w_new_a  = PORT_AW'(w_off >> 1);
  assign w_new_ds = ioctl_addr[0] ? DS_HI : DS_LO;
  assign w_new_d  = {ioctl_dout, ioctl_dout};

  assign w_idx_ok     = ((ioctl_index ^ DL_INDEX) & INDEX_MASK) == 8'h00;
  // Bytes below the first region are silently ignored: not counted, no overflow.
  assign w_accept     = ioctl_wr & ~r_wr_d & ioctl_downl & w_idx_ok & (w_region >= 0);
  assign w_downl_rise = ioctl_downl & ~r_downl_d;
  assign w_downl_fall = ~ioctl_downl & r_downl_d;

  always_comb begin
    w_state_nxt  = r_state;
    w_issue_new  = 1'b0;
    w_issue_pend = 1'b0;
    w_fill_pend  = 1'b0;
    w_drop       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_pend_vld) begin
          w_issue_pend = 1'b1;
          w_fill_pend  = w_accept;
          w_state_nxt  = WAIT_ACK;
        end else if (w_accept) begin
          w_issue_new = 1'b1;
          w_state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (w_accept) begin
          if (r_pend_vld) w_drop      = 1'b1;
          else            w_fill_pend = 1'b1;
        end
        // req flips the cycle after capture, so ack is only meaningful once r_issue has retired
        if (!r_issue && !(|(r_cur_oh & w_busy))) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_issue    <= 1'b0;
      r_cur_oh   <= '0;
      r_a        <= '0;
      r_ds       <= '0;
      r_d        <= '0;
      r_pend_vld <= 1'b0;
      r_pend_oh  <= '0;
      r_pend_a   <= '0;
      r_pend_ds  <= '0;
      r_pend_d   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_issue <= w_issue_new | w_issue_pend;
      if (w_issue_pend) begin
        r_cur_oh <= r_pend_oh;
        r_a      <= r_pend_a;
        r_ds     <= r_pend_ds;
        r_d      <= r_pend_d;
      end else if (w_issue_new) begin
        r_cur_oh <= w_new_oh;
        r_a      <= w_new_a;
        r_ds     <= w_new_ds;
        r_d      <= w_new_d;
      end
      if (w_fill_pend) begin
        r_pend_vld <= 1'b1;
        r_pend_oh  <= w_new_oh;
        r_pend_a   <= w_new_a;
        r_pend_ds  <= w_new_ds;
        r_pend_d   <= w_new_d;
      end else if (w_issue_pend) begin
        r_pend_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_wr_d     <= 1'b0;
      r_downl_d  <= 1'b0;
      r_bytes    <= '0;
      r_ovf      <= 1'b0;
      r_loaded   <= 1'b0;
      r_done_req <= 1'b0;
    end else begin
      r_wr_d    <= ioctl_wr;
      r_downl_d <= ioctl_downl;
      if (w_downl_rise) begin
        r_bytes    <= '0;
        r_ovf      <= 1'b0;
        r_loaded   <= 1'b0;
        r_done_req <= 1'b0;
      end else begin
        if (w_done) r_bytes <= r_bytes + ADDR_W'(1);
        if (w_drop) r_ovf   <= 1'b1;
        if (w_downl_fall)
          r_done_req <= 1'b1;
        else if (r_done_req && r_state == IDLE && !r_pend_vld && r_bytes != '0) begin
          r_loaded   <= 1'b1;
          r_done_req <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_cnt      <= CW'(RESET_STRETCH);
      r_core_rst <= 1'b1;
    end else if (user_reset || !r_loaded) begin
      r_cnt      <= CW'(RESET_STRETCH);
      r_core_rst <= 1'b1;
    end else if (r_cnt != '0) begin
      r_cnt      <= r_cnt - CW'(1);
      r_core_rst <= (r_cnt != CW'(1));
    end else begin
      r_core_rst <= 1'b0;
    end
  end

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
    toggle_req_port u_port (
      .i_clk    (clk_sys),
      .i_rst    (reset),
      .i_toggle (r_issue & r_cur_oh[k]),
      .i_ack    (port_ack[k]),
      .o_req    (w_req[k]),
      .o_busy   (w_busy[k])
    );
  end

  assign port_req      = w_req;
  assign port_a        = r_a;
  assign port_ds       = r_ds;
  assign port_d        = r_d;
  assign port_we       = ioctl_downl;
  assign rom_loaded    = r_loaded;
  assign core_reset    = r_core_rst;
  assign overflow      = r_ovf;
  assign bytes_written = r_bytes;

endmodule

// File: tb/tb_rom_download_router.sv
// Scenario bench for rom_download_router: randomized bytes checked against a
// region/word-address model, plus buffering, completion and reset timing.
module tb_rom_download_router;

  localparam int NP  = 2;
  localparam int AW  = 25;
  localparam int PAW = 23;
  localparam int RS  = 16;

  logic           clk_sys = 1'b0;
  logic           reset = 1'b1;
  logic           user_reset = 1'b0;
  logic           ioctl_downl = 1'b0;
  logic [7:0]     ioctl_index = 8'h00;
  logic           ioctl_wr = 1'b0;
  logic [AW-1:0]  ioctl_addr = '0;
  logic [7:0]     ioctl_dout = 8'h00;
  logic [NP-1:0]  port_ack = '0;
  logic [NP-1:0]  port_req;
  logic [PAW-1:0] port_a;
  logic [1:0]     port_ds;
  logic [15:0]    port_d;
  logic           port_we, rom_loaded, core_reset, overflow;
  logic [AW-1:0]  bytes_written;

  logic [NP-1:0]  b_req;
  logic [PAW-1:0] b_a;
  logic [1:0]     b_ds;
  logic [15:0]    b_d;
  logic           b_we, b_loaded, b_core_rst, b_ovf;
  logic [AW-1:0]  b_bytes;

  int n_chk = 0;
  int n_fail = 0;
  int ack_dly = 3;

  rom_download_router dut (
    .clk_sys(clk_sys), .reset(reset), .user_reset(user_reset),
    .ioctl_downl(ioctl_downl), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .port_req(port_req), .port_ack(port_ack), .port_a(port_a), .port_ds(port_ds),
    .port_d(port_d), .port_we(port_we), .rom_loaded(rom_loaded),
    .core_reset(core_reset), .overflow(overflow), .bytes_written(bytes_written)
  );

  // Second instance only accepts index 1; its acks are echoed instantly.
  rom_download_router #(.DL_INDEX(8'h01), .INDEX_MASK(8'hFF)) dut_idx (
    .clk_sys(clk_sys), .reset(reset), .user_reset(user_reset),
    .ioctl_downl(ioctl_downl), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .port_req(b_req), .port_ack(b_req), .port_a(b_a), .port_ds(b_ds),
    .port_d(b_d), .port_we(b_we), .rom_loaded(b_loaded),
    .core_reset(b_core_rst), .overflow(b_ovf), .bytes_written(b_bytes)
  );

  always #5 clk_sys = ~clk_sys;

  // SDRAM stand-in: echoes each port's req onto its ack ack_dly cycles later.
  int ack_cnt [NP];
  always @(posedge clk_sys) begin
    #1;
    for (int k = 0; k < NP; k++) begin
      if (reset) begin
        port_ack[k] = 1'b0;
        ack_cnt[k]  = 0;
      end else if (port_req[k] != port_ack[k]) begin
        ack_cnt[k]++;
        if (ack_cnt[k] >= ack_dly) begin
          port_ack[k] = port_req[k];
          ack_cnt[k]  = 0;
        end
      end else begin
        ack_cnt[k] = 0;
      end
    end
  end

  typedef struct {
    logic [NP-1:0]  mask;
    logic [PAW-1:0] a;
    logic [1:0]     ds;
    logic [15:0]    d;
  } issue_t;

  issue_t        log_q[$];
  logic [NP-1:0] prev_req = '0;
  always @(negedge clk_sys) begin
    if (port_req != prev_req) log_q.push_back('{port_req ^ prev_req, port_a, port_ds, port_d});
    prev_req = port_req;
  end

  logic [AW-1:0] base_tab [NP] = '{25'h00000, 25'h10000};

  function automatic issue_t model(input logic [AW-1:0] addr, input logic [7:0] dout);
    issue_t e;
    int k;
    k = -1;
    for (int i = 0; i < NP; i++) if (addr >= base_tab[i]) k = i;
    e.mask = (k < 0) ? '0 : (NP'(1) << k);
    e.a    = (k < 0) ? '0 : PAW'((addr - base_tab[k]) / 2);
    e.ds   = addr[0] ? 2'b10 : 2'b01;
    e.d    = {dout, dout};
    return e;
  endfunction

  task automatic pulse_wr(input logic [AW-1:0] a, input logic [7:0] d);
    @(negedge clk_sys);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_log(input int n, input int budget);
    for (int i = 0; i < budget && log_q.size() < n; i++) @(negedge clk_sys);
  endtask

  task automatic wait_bytes(input int n, input int budget);
    for (int i = 0; i < budget && bytes_written != AW'(n); i++) @(negedge clk_sys);
  endtask

  task automatic wait_loaded(input int budget);
    for (int i = 0; i < budget && rom_loaded !== 1'b1; i++) @(negedge clk_sys);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_sys);
    ioctl_downl = 1'b1;
    @(negedge clk_sys);
    n_chk++; if (port_req !== '0) begin n_fail++; $display("FAIL rst_req: got %b exp 0", port_req); end
    n_chk++; if (port_a !== '0 || port_ds !== 2'b00 || port_d !== 16'h0) begin
      n_fail++; $display("FAIL rst_data: a=%h ds=%b d=%h exp all 0", port_a, port_ds, port_d); end
    n_chk++; if (rom_loaded !== 1'b0 || overflow !== 1'b0 || bytes_written !== '0) begin
      n_fail++; $display("FAIL rst_status: loaded=%b ovf=%b bytes=%0d exp 0/0/0", rom_loaded, overflow, bytes_written); end
    n_chk++; if (core_reset !== 1'b1) begin n_fail++; $display("FAIL rst_core: got %b exp 1", core_reset); end
    n_chk++; if (port_we !== 1'b1) begin n_fail++; $display("FAIL rst_we: got %b exp 1", port_we); end
    ioctl_downl = 1'b0;
    @(negedge clk_sys);
    reset = 1'b0;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic test_route();
    logic [AW-1:0] addrs [10];
    logic [7:0]    dats  [10];
    issue_t e, ex;
    addrs[0] = 25'h00004; dats[0] = 8'hA5;
    addrs[1] = 25'h10003; dats[1] = 8'h5A;
    addrs[2] = 25'h0FFFF; addrs[3] = 25'h10000;
    for (int i = 2; i < 10; i++) dats[i] = 8'($urandom);
    for (int i = 4; i < 10; i++) addrs[i] = AW'($urandom_range(0, 32'hFFFFFF));
    @(negedge clk_sys); ioctl_downl = 1'b1;
    repeat (2) @(negedge clk_sys);
    log_q.delete();
    for (int i = 0; i < 10; i++) begin
      ex = model(addrs[i], dats[i]);
      pulse_wr(addrs[i], dats[i]);
      wait_log(1, 20);
      n_chk++;
      if (log_q.size() == 0) begin
        n_fail++; $display("FAIL route%0d_issue: no req toggle for addr %h", i, addrs[i]);
      end else begin
        e = log_q.pop_front();
        if (e.mask !== ex.mask || e.a !== ex.a || e.ds !== ex.ds || e.d !== ex.d) begin
          n_fail++;
          $display("FAIL route%0d addr=%h: got mask=%b a=%h ds=%b d=%h exp mask=%b a=%h ds=%b d=%h",
                   i, addrs[i], e.mask, e.a, e.ds, e.d, ex.mask, ex.a, ex.ds, ex.d);
        end
      end
      wait_bytes(i + 1, 20);
      n_chk++; if (bytes_written !== AW'(i + 1)) begin
        n_fail++; $display("FAIL route%0d_bytes: got %0d exp %0d", i, bytes_written, i + 1); end
    end
    n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL route_ovf: got %b exp 0", overflow); end
    ioctl_downl = 1'b0;
    wait_loaded(20);
    n_chk++; if (rom_loaded !== 1'b1) begin n_fail++; $display("FAIL route_loaded: got %b exp 1", rom_loaded); end
  endtask

  task automatic test_overflow();
    logic [AW-1:0] a [3];
    logic [7:0]    d [3];
    issue_t e, ex;
    for (int i = 0; i < 3; i++) begin
      a[i] = AW'($urandom_range(0, 32'h3FFFF));
      d[i] = 8'($urandom);
    end
    @(negedge clk_sys); ioctl_downl = 1'b1;
    repeat (2) @(negedge clk_sys);
    n_chk++; if (rom_loaded !== 1'b0 || bytes_written !== '0) begin
      n_fail++; $display("FAIL start_clear: loaded=%b bytes=%0d exp 0/0", rom_loaded, bytes_written); end
    ack_dly = 10;
    log_q.delete();
    for (int i = 0; i < 3; i++) pulse_wr(a[i], d[i]);
    wait_log(2, 60);
    repeat (30) @(negedge clk_sys);
    n_chk++; if (log_q.size() != 2) begin
      n_fail++; $display("FAIL ovf_issues: got %0d issues exp 2", log_q.size()); end
    for (int i = 0; i < 2; i++) begin
      ex = model(a[i], d[i]);
      n_chk++;
      if (log_q.size() == 0) begin
        n_fail++; $display("FAIL ovf_order%0d: missing issue", i);
      end else begin
        e = log_q.pop_front();
        if (e.mask !== ex.mask || e.a !== ex.a || e.ds !== ex.ds || e.d !== ex.d) begin
          n_fail++;
          $display("FAIL ovf_order%0d: got mask=%b a=%h ds=%b d=%h exp mask=%b a=%h ds=%b d=%h",
                   i, e.mask, e.a, e.ds, e.d, ex.mask, ex.a, ex.ds, ex.d);
        end
      end
    end
    n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b exp 1", overflow); end
    n_chk++; if (bytes_written !== AW'(2)) begin n_fail++; $display("FAIL ovf_bytes: got %0d exp 2", bytes_written); end
    ack_dly = 3;
    ioctl_downl = 1'b0;
    wait_loaded(20);
  endtask

  task automatic test_restart_zero();
    @(negedge clk_sys); ioctl_downl = 1'b1;
    repeat (3) @(negedge clk_sys);
    n_chk++; if (overflow !== 1'b0 || bytes_written !== '0 || rom_loaded !== 1'b0) begin
      n_fail++; $display("FAIL restart_clear: ovf=%b bytes=%0d loaded=%b exp 0/0/0", overflow, bytes_written, rom_loaded); end
    n_chk++; if (core_reset !== 1'b1) begin n_fail++; $display("FAIL restart_core: got %b exp 1", core_reset); end
    ioctl_downl = 1'b0;
    repeat (10) @(negedge clk_sys);
    n_chk++; if (rom_loaded !== 1'b0) begin n_fail++; $display("FAIL zero_dl_loaded: got %b exp 0", rom_loaded); end
  endtask

  task automatic test_complete();
    logic [AW-1:0] a;
    logic [7:0]    d;
    issue_t e, ex;
    int rel;
    @(negedge clk_sys); ioctl_downl = 1'b1;
    repeat (2) @(negedge clk_sys);
    for (int i = 0; i < 3; i++) begin
      pulse_wr(AW'($urandom_range(0, 32'h3FFFF)), 8'($urandom));
      wait_bytes(i + 1, 20);
    end
    log_q.delete();
    a = AW'($urandom_range(0, 32'h3FFFF));
    d = 8'($urandom);
    ex = model(a, d);
    @(negedge clk_sys);
    ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0; ioctl_downl = 1'b0;
    @(negedge clk_sys);
    n_chk++; if (rom_loaded !== 1'b0) begin n_fail++; $display("FAIL cmp_early: loaded=%b with ack outstanding", rom_loaded); end
    wait_loaded(40);
    n_chk++; if (rom_loaded !== 1'b1 || bytes_written !== AW'(4)) begin
      n_fail++; $display("FAIL cmp_loaded: loaded=%b bytes=%0d exp 1/4", rom_loaded, bytes_written); end
    n_chk++;
    if (log_q.size() == 0) begin
      n_fail++; $display("FAIL cmp_last_issue: missing");
    end else begin
      e = log_q.pop_front();
      if (e.mask !== ex.mask || e.a !== ex.a || e.ds !== ex.ds || e.d !== ex.d) begin
        n_fail++; $display("FAIL cmp_last_issue: got a=%h d=%h exp a=%h d=%h", e.a, e.d, ex.a, ex.d);
      end
    end
    rel = -1;
    for (int n = 0; n <= RS + 4; n++) begin
      if (n > 0) @(negedge clk_sys);
      if (core_reset === 1'b0) begin rel = n; break; end
    end
    n_chk++; if (rel != RS) begin n_fail++; $display("FAIL cmp_stretch: core_reset fell after %0d cycles exp %0d", rel, RS); end
  endtask

  task automatic test_index();
    @(negedge clk_sys); ioctl_index = 8'h00; ioctl_downl = 1'b1;
    repeat (2) @(negedge clk_sys);
    for (int i = 0; i < 4; i++) begin
      pulse_wr(AW'($urandom_range(0, 32'h3FFFF)), 8'($urandom));
      wait_bytes(i + 1, 20);
    end
    ioctl_downl = 1'b0;
    repeat (30) @(negedge clk_sys);
    n_chk++; if (b_req !== '0 || b_bytes !== '0) begin
      n_fail++; $display("FAIL idx_reject: req=%b bytes=%0d exp 0/0", b_req, b_bytes); end
    n_chk++; if (b_loaded !== 1'b0 || b_core_rst !== 1'b1) begin
      n_fail++; $display("FAIL idx_status: loaded=%b core_reset=%b exp 0/1", b_loaded, b_core_rst); end
    @(negedge clk_sys); ioctl_index = 8'h01; ioctl_downl = 1'b1;
    repeat (2) @(negedge clk_sys);
    for (int i = 0; i < 2; i++) begin
      pulse_wr(AW'($urandom_range(0, 32'h3FFFF)), 8'($urandom));
      wait_bytes(i + 1, 20);
    end
    ioctl_downl = 1'b0;
    repeat (5) @(negedge clk_sys);
    n_chk++; if (b_bytes !== AW'(2) || b_loaded !== 1'b1) begin
      n_fail++; $display("FAIL idx_accept: bytes=%0d loaded=%b exp 2/1", b_bytes, b_loaded); end
    ioctl_index = 8'h00;
  endtask

  task automatic test_user_reset();
    int p, rel;
    for (int i = 0; i < 40 && core_reset !== 1'b0; i++) @(negedge clk_sys);
    n_chk++; if (core_reset !== 1'b0) begin n_fail++; $display("FAIL ures_pre: core_reset=%b exp 0", core_reset); end
    p = $urandom_range(1, 6);
    user_reset = 1'b1;
    rel = -1;
    for (int j = 1; j <= p + RS + 8; j++) begin
      @(negedge clk_sys);
      if (core_reset === 1'b0 && rel < 0) rel = j;
      if (j == p) user_reset = 1'b0;
    end
    n_chk++; if (rel != p + RS) begin
      n_fail++; $display("FAIL ures_len: pulse %0d released after %0d cycles exp %0d", p, rel, p + RS); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk_sys); ioctl_downl = 1'b1;
    repeat (2) @(negedge clk_sys);
    ack_dly = 10;
    log_q.delete();
    pulse_wr(AW'($urandom_range(0, 32'h3FFFF)), 8'($urandom));
    pulse_wr(AW'($urandom_range(0, 32'h3FFFF)), 8'($urandom));
    n_chk++; if (log_q.size() != 1) begin n_fail++; $display("FAIL mid_inflight: issues=%0d exp 1", log_q.size()); end
    @(posedge clk_sys);
    #2 reset = 1'b1;
    #1;
    n_chk++; if (port_req !== '0 || port_a !== '0 || port_ds !== 2'b00 || port_d !== 16'h0) begin
      n_fail++; $display("FAIL mid_rst_port: req=%b a=%h ds=%b d=%h exp all 0", port_req, port_a, port_ds, port_d); end
    n_chk++; if (rom_loaded !== 1'b0 || overflow !== 1'b0 || bytes_written !== '0 || core_reset !== 1'b1) begin
      n_fail++; $display("FAIL mid_rst_status: loaded=%b ovf=%b bytes=%0d core=%b exp 0/0/0/1",
                         rom_loaded, overflow, bytes_written, core_reset); end
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    ack_dly = 3;
    log_q.delete();
    repeat (25) @(negedge clk_sys);
    n_chk++; if (log_q.size() != 0 || bytes_written !== '0) begin
      n_fail++; $display("FAIL mid_pending_dropped: issues=%0d bytes=%0d exp 0/0", log_q.size(), bytes_written); end
    ioctl_downl = 1'b0;
    repeat (3) @(negedge clk_sys);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_route();
    test_overflow();
    test_restart_zero();
    test_complete();
    test_index();
    test_user_reset();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
